// File: rtl/ber_window_monitor_if.sv
// Sample stream, window configuration, report handshake and status flags of the BER window monitor.
// The monitor connects through the slave modport; the host or readout side uses master.
interface ber_window_monitor_if #(
    parameter int unsigned IDX_W = 16
);
    logic             enable;
    logic             err_valid;
    logic [12:0]      err_in;
    logic [24:0]      window_len;
    logic [24:0]      threshold;
    logic             alarm_clr;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [24:0]      rpt_err_cnt;
    logic [31:0]      rpt_err_sum;
    logic [IDX_W-1:0] rpt_idx;
    logic             locked;
    logic             alarm;
    logic             overrun;

    modport master (
        output enable, err_valid, err_in, window_len, threshold, alarm_clr, rpt_ready,
        input  rpt_valid, rpt_err_cnt, rpt_err_sum, rpt_idx, locked, alarm, overrun
    );

    modport slave (
        input  enable, err_valid, err_in, window_len, threshold, alarm_clr, rpt_ready,
        output rpt_valid, rpt_err_cnt, rpt_err_sum, rpt_idx, locked, alarm, overrun
    );
endinterface

// File: rtl/ber_window_monitor.sv
// Windowed bit-error monitor: qualifies sync on a run of clean samples, then reports per-window
// error count and saturating |error| sum over a valid/ready slot, with sticky alarm/overrun flags.
module ber_window_monitor #(
    parameter int unsigned SYNC_GOOD    = 16,
    parameter int unsigned LOSS_WINDOWS = 3,
    parameter int unsigned IDX_W        = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    ber_window_monitor_if.slave  bus
);
    localparam int unsigned GOOD_W = $clog2(SYNC_GOOD + 1);
    localparam int unsigned BAD_W  = $clog2(LOSS_WINDOWS + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_ACCUM   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [GOOD_W-1:0]  r_good_cnt;
    logic [BAD_W-1:0]   r_bad_run;
    logic [24:0]        r_len;
    logic [24:0]        r_smp_cnt;
    logic [24:0]        r_err_cnt;
    logic [31:0]        r_err_sum;
    logic [IDX_W-1:0]   r_idx;

    logic               r_rpt_valid;
    logic [24:0]        r_rpt_err_cnt;
    logic [31:0]        r_rpt_err_sum;
    logic [IDX_W-1:0]   r_rpt_idx;
    logic               r_locked;
    logic               r_alarm;
    logic               r_overrun;

    logic               w_sample;
    logic               w_nonzero;
    logic [13:0]        w_err_ext;
    logic [13:0]        w_abs;
    logic [32:0]        w_sum_wide;
    logic [31:0]        w_sum_next;
    logic [24:0]        w_cnt_next;
    logic [24:0]        w_smp_next;
    logic [24:0]        w_len_in;
    logic [GOOD_W-1:0]  w_good_next;
    logic [BAD_W-1:0]   w_bad_next;
    logic               w_in_acq;
    logic               w_in_accum;
    logic               w_sync_hit;
    logic               w_close;
    logic               w_bad;
    logic               w_loss;
    logic               w_slot_free;
    logic               w_load;
    logic               w_drop;

    assign w_sample   = bus.err_valid;
    assign w_nonzero  = |bus.err_in;
    assign w_in_acq   = (r_state == ST_ACQUIRE) && bus.enable;
    assign w_in_accum = (r_state == ST_ACCUM) && bus.enable;

    // 14-bit magnitude so that -4096 maps to +4096 without wrapping
    assign w_err_ext  = {bus.err_in[12], bus.err_in};
    assign w_abs      = bus.err_in[12] ? (~w_err_ext + 14'd1) : w_err_ext;
    assign w_sum_wide = {1'b0, r_err_sum} + {19'd0, w_abs};
    assign w_sum_next = w_sum_wide[32] ? '1 : w_sum_wide[31:0];
    assign w_cnt_next = r_err_cnt + {24'd0, w_nonzero};
    assign w_smp_next = r_smp_cnt + 25'd1;
    assign w_len_in   = (bus.window_len == '0) ? 25'd1 : bus.window_len;

    assign w_good_next = r_good_cnt + 1'b1;
    assign w_sync_hit  = w_in_acq && w_sample && !w_nonzero &&
                         (w_good_next == GOOD_W'(SYNC_GOOD));

    // The closing sample belongs to the window it closes
    assign w_close     = w_in_accum && w_sample && (w_smp_next == r_len);
    assign w_bad       = w_close && (w_cnt_next > bus.threshold);
    assign w_bad_next  = r_bad_run + 1'b1;
    assign w_loss      = w_bad && (w_bad_next == BAD_W'(LOSS_WINDOWS));

    assign w_slot_free = !r_rpt_valid || bus.rpt_ready;
    assign w_load      = w_close && w_slot_free;
    assign w_drop      = w_close && !w_slot_free;

    always_comb begin
        w_state_next = r_state;
        if (!bus.enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_next = ST_ACQUIRE;
                ST_ACQUIRE: if (w_sync_hit) w_state_next = ST_ACCUM;
                ST_ACCUM:   if (w_loss) w_state_next = ST_ACQUIRE;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_good_cnt <= '0;
        end else if (!w_in_acq) begin
            r_good_cnt <= '0;
        end else if (w_sample) begin
            r_good_cnt <= (w_nonzero || w_sync_hit) ? '0 : w_good_next;
        end
    end

    // Window accumulators; anything outside an enabled ACCUM discards the partial window
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_len     <= '0;
            r_smp_cnt <= '0;
            r_err_cnt <= '0;
            r_err_sum <= '0;
        end else if (w_sync_hit || w_close) begin
            r_len     <= w_len_in;
            r_smp_cnt <= '0;
            r_err_cnt <= '0;
            r_err_sum <= '0;
        end else if (w_in_accum) begin
            if (w_sample) begin
                r_smp_cnt <= w_smp_next;
                r_err_cnt <= w_cnt_next;
                r_err_sum <= w_sum_next;
            end
        end else begin
            r_smp_cnt <= '0;
            r_err_cnt <= '0;
            r_err_sum <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bad_run <= '0;
            r_idx     <= '0;
        end else begin
            if (w_sync_hit) begin
                r_bad_run <= '0;
            end else if (w_close) begin
                r_bad_run <= (w_bad && !w_loss) ? w_bad_next : '0;
            end
            if (w_close) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rpt_valid   <= 1'b0;
            r_rpt_err_cnt <= '0;
            r_rpt_err_sum <= '0;
            r_rpt_idx     <= '0;
        end else if (w_load) begin
            r_rpt_valid   <= 1'b1;
            r_rpt_err_cnt <= w_cnt_next;
            r_rpt_err_sum <= w_sum_next;
            r_rpt_idx     <= r_idx;
        end else if (bus.rpt_ready) begin
            r_rpt_valid   <= 1'b0;
        end
    end

    // Sticky flags: a set event on the clearing edge wins
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_alarm   <= 1'b0;
            r_overrun <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_alarm   <= (r_alarm && !bus.alarm_clr) || w_bad;
            r_overrun <= (r_overrun && !bus.alarm_clr) || w_drop;
            r_locked  <= (w_state_next == ST_ACCUM);
        end
    end

    assign bus.rpt_valid   = r_rpt_valid;
    assign bus.rpt_err_cnt = r_rpt_err_cnt;
    assign bus.rpt_err_sum = r_rpt_err_sum;
    assign bus.rpt_idx     = r_rpt_idx;
    assign bus.locked      = r_locked;
    assign bus.alarm       = r_alarm;
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_ber_window_monitor.sv
// Directed bench for ber_window_monitor: sync acquisition, window reports, overrun, alarm,
// loss of sync, magnitude/saturation, async reset and alarm clearing.
module tb_ber_window_monitor;
    logic clock = 1'b0;
    logic reset_n;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    ber_window_monitor_if #(.IDX_W(16)) bus ();

    ber_window_monitor #(
        .SYNC_GOOD   (16),
        .LOSS_WINDOWS(3),
        .IDX_W       (16)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [12:0] v);
        bus.err_valid = 1'b1;
        bus.err_in    = v;
        @(posedge clock);
        #1;
        bus.err_valid = 1'b0;
        bus.err_in    = 13'h0000;
    endtask

    task automatic do_reset();
        bus.enable     = 1'b0;
        bus.err_valid  = 1'b0;
        bus.err_in     = 13'h0000;
        bus.window_len = 25'd0;
        bus.threshold  = 25'd100;
        bus.alarm_clr  = 1'b0;
        bus.rpt_ready  = 1'b0;
        reset_n        = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic lock(input logic [24:0] len);
        bus.window_len = len;
        bus.enable     = 1'b1;
        tick();
        repeat (16) send(13'h0000);
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++;
        if ({bus.rpt_valid, bus.locked, bus.alarm, bus.overrun} !== 4'b0000) begin
            miss_cnt++;
            $display("FAIL reset_flags: got %b want 0000", {bus.rpt_valid, bus.locked, bus.alarm, bus.overrun});
        end
        vec_cnt++;
        if ({bus.rpt_err_cnt, bus.rpt_err_sum} !== 57'd0) begin
            miss_cnt++;
            $display("FAIL reset_data: got cnt %0d sum %0h want 0 0", bus.rpt_err_cnt, bus.rpt_err_sum);
        end
        vec_cnt++;
        if (bus.rpt_idx !== 16'd0) begin
            miss_cnt++;
            $display("FAIL reset_idx: got %0d want 0", bus.rpt_idx);
        end
    endtask

    task automatic test_basic();
        do_reset();
        bus.window_len = 25'd4;
        bus.rpt_ready  = 1'b1;
        bus.enable     = 1'b1;
        tick();
        repeat (10) send(13'h0000);
        send(13'h0003);
        repeat (15) send(13'h0000);
        vec_cnt++;
        if (bus.locked !== 1'b0) begin
            miss_cnt++;
            $display("FAIL acq_15th: got locked %b want 0", bus.locked);
        end
        send(13'h0000);
        vec_cnt++;
        if (bus.locked !== 1'b1) begin
            miss_cnt++;
            $display("FAIL acq_16th: got locked %b want 1", bus.locked);
        end
        send(13'h0000);
        send(13'h0005);
        send(13'h1FFB);
        vec_cnt++;
        if (bus.rpt_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL basic_early: got valid %b want 0", bus.rpt_valid);
        end
        send(13'h0000);
        vec_cnt++;
        if (bus.rpt_valid !== 1'b1) begin
            miss_cnt++;
            $display("FAIL basic_valid: got %b want 1", bus.rpt_valid);
        end
        vec_cnt++;
        if (bus.rpt_err_cnt !== 25'd2) begin
            miss_cnt++;
            $display("FAIL basic_cnt: got %0d want 2", bus.rpt_err_cnt);
        end
        vec_cnt++;
        if (bus.rpt_err_sum !== 32'd10) begin
            miss_cnt++;
            $display("FAIL basic_sum: got %0d want 10", bus.rpt_err_sum);
        end
        vec_cnt++;
        if (bus.rpt_idx !== 16'd0) begin
            miss_cnt++;
            $display("FAIL basic_idx: got %0d want 0", bus.rpt_idx);
        end
        tick();
        vec_cnt++;
        if (bus.rpt_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL basic_pulse: got valid %b want 0", bus.rpt_valid);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        lock(25'd2);
        send(13'h0000);
        send(13'h0000);
        vec_cnt++;
        if ({bus.rpt_valid, bus.overrun} !== 2'b10) begin
            miss_cnt++;
            $display("FAIL ovr_first: got valid/overrun %b want 10", {bus.rpt_valid, bus.overrun});
        end
        send(13'h0000);
        send(13'h0000);
        vec_cnt++;
        if ({bus.rpt_valid, bus.overrun} !== 2'b11) begin
            miss_cnt++;
            $display("FAIL ovr_drop: got valid/overrun %b want 11", {bus.rpt_valid, bus.overrun});
        end
        send(13'h0000);
        send(13'h0000);
        vec_cnt++;
        if (bus.rpt_idx !== 16'd0) begin
            miss_cnt++;
            $display("FAIL ovr_held_idx: got %0d want 0", bus.rpt_idx);
        end
        bus.rpt_ready = 1'b1;
        tick();
        vec_cnt++;
        if (bus.rpt_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL ovr_accept: got valid %b want 0", bus.rpt_valid);
        end
        send(13'h0000);
        send(13'h0000);
        vec_cnt++;
        if ({bus.rpt_valid, bus.rpt_idx} !== {1'b1, 16'd3}) begin
            miss_cnt++;
            $display("FAIL ovr_next_idx: got valid %b idx %0d want 1 3", bus.rpt_valid, bus.rpt_idx);
        end
        bus.alarm_clr = 1'b1;
        tick();
        bus.alarm_clr = 1'b0;
        vec_cnt++;
        if (bus.overrun !== 1'b0) begin
            miss_cnt++;
            $display("FAIL ovr_clear: got %b want 0", bus.overrun);
        end
    endtask

    task automatic test_alarm_loss();
        do_reset();
        bus.threshold = 25'd0;
        bus.rpt_ready = 1'b1;
        lock(25'd1);
        send(13'h0007);
        vec_cnt++;
        if ({bus.alarm, bus.locked, bus.rpt_valid} !== 3'b111) begin
            miss_cnt++;
            $display("FAIL alarm_first: got alarm/locked/valid %b want 111", {bus.alarm, bus.locked, bus.rpt_valid});
        end
        vec_cnt++;
        if ({bus.rpt_err_cnt, bus.rpt_err_sum} !== {25'd1, 32'd7}) begin
            miss_cnt++;
            $display("FAIL alarm_data: got cnt %0d sum %0d want 1 7", bus.rpt_err_cnt, bus.rpt_err_sum);
        end
        send(13'h0007);
        vec_cnt++;
        if (bus.locked !== 1'b1) begin
            miss_cnt++;
            $display("FAIL loss_second: got locked %b want 1", bus.locked);
        end
        send(13'h0007);
        vec_cnt++;
        if (bus.locked !== 1'b0) begin
            miss_cnt++;
            $display("FAIL loss_third: got locked %b want 0", bus.locked);
        end
        vec_cnt++;
        if ({bus.rpt_valid, bus.rpt_idx} !== {1'b1, 16'd2}) begin
            miss_cnt++;
            $display("FAIL loss_report: got valid %b idx %0d want 1 2", bus.rpt_valid, bus.rpt_idx);
        end
        repeat (16) send(13'h0000);
        vec_cnt++;
        if (bus.locked !== 1'b1) begin
            miss_cnt++;
            $display("FAIL relock: got locked %b want 1", bus.locked);
        end
        send(13'h0007);
        vec_cnt++;
        if ({bus.rpt_valid, bus.rpt_idx} !== {1'b1, 16'd3}) begin
            miss_cnt++;
            $display("FAIL relock_idx: got valid %b idx %0d want 1 3", bus.rpt_valid, bus.rpt_idx);
        end
    endtask

    task automatic test_sum_sat();
        do_reset();
        lock(25'd2);
        bus.window_len = 25'h100000;
        send(13'h1000);
        send(13'h1000);
        vec_cnt++;
        if ({bus.rpt_valid, bus.rpt_err_cnt, bus.rpt_err_sum} !== {1'b1, 25'd2, 32'd8192}) begin
            miss_cnt++;
            $display("FAIL sum_min: got valid %b cnt %0d sum %0d want 1 2 8192", bus.rpt_valid, bus.rpt_err_cnt, bus.rpt_err_sum);
        end
        // preload the open 2^20-sample window to 3 samples before close, 12288 short of wrap
        dut.r_err_sum = 32'hFFFF_D000;
        dut.r_smp_cnt = 25'h0FFFFD;
        bus.rpt_ready = 1'b1;
        send(13'h1000);
        send(13'h1000);
        vec_cnt++;
        if (bus.rpt_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL sat_early: got valid %b want 0", bus.rpt_valid);
        end
        send(13'h1000);
        vec_cnt++;
        if ({bus.rpt_valid, bus.rpt_err_sum} !== {1'b1, 32'hFFFF_FFFF}) begin
            miss_cnt++;
            $display("FAIL sat_sum: got valid %b sum %0h want 1 ffffffff", bus.rpt_valid, bus.rpt_err_sum);
        end
        vec_cnt++;
        if ({bus.rpt_err_cnt, bus.rpt_idx} !== {25'd3, 16'd1}) begin
            miss_cnt++;
            $display("FAIL sat_cnt_idx: got cnt %0d idx %0d want 3 1", bus.rpt_err_cnt, bus.rpt_idx);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.threshold = 25'd0;
        lock(25'd4);
        send(13'h0003);
        send(13'h0000);
        send(13'h0000);
        send(13'h0000);
        vec_cnt++;
        if ({bus.rpt_valid, bus.alarm, bus.locked} !== 3'b111) begin
            miss_cnt++;
            $display("FAIL prereset: got valid/alarm/locked %b want 111", {bus.rpt_valid, bus.alarm, bus.locked});
        end
        send(13'h0000);
        #2;
        reset_n = 1'b0;
        #1;
        vec_cnt++;
        if ({bus.rpt_valid, bus.locked, bus.alarm, bus.overrun} !== 4'b0000) begin
            miss_cnt++;
            $display("FAIL async_flags: got %b want 0000", {bus.rpt_valid, bus.locked, bus.alarm, bus.overrun});
        end
        vec_cnt++;
        if ({bus.rpt_err_cnt, bus.rpt_err_sum, bus.rpt_idx} !== 73'd0) begin
            miss_cnt++;
            $display("FAIL async_data: got cnt %0d sum %0d idx %0d want 0 0 0", bus.rpt_err_cnt, bus.rpt_err_sum, bus.rpt_idx);
        end
        reset_n = 1'b1;
        tick();
        repeat (15) send(13'h0000);
        vec_cnt++;
        if (bus.locked !== 1'b0) begin
            miss_cnt++;
            $display("FAIL post_reset_acq: got locked %b want 0", bus.locked);
        end
        send(13'h0000);
        vec_cnt++;
        if (bus.locked !== 1'b1) begin
            miss_cnt++;
            $display("FAIL post_reset_lock: got locked %b want 1", bus.locked);
        end
    endtask

    task automatic test_alarm_clr();
        do_reset();
        bus.threshold = 25'd0;
        bus.rpt_ready = 1'b1;
        lock(25'd1);
        send(13'h0007);
        vec_cnt++;
        if (bus.alarm !== 1'b1) begin
            miss_cnt++;
            $display("FAIL clr_set: got alarm %b want 1", bus.alarm);
        end
        bus.alarm_clr = 1'b1;
        send(13'h0007);
        vec_cnt++;
        if (bus.alarm !== 1'b1) begin
            miss_cnt++;
            $display("FAIL clr_set_wins: got alarm %b want 1", bus.alarm);
        end
        tick();
        bus.alarm_clr = 1'b0;
        vec_cnt++;
        if (bus.alarm !== 1'b0) begin
            miss_cnt++;
            $display("FAIL clr_alone: got alarm %b want 0", bus.alarm);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_alarm_loss();
        test_sum_sat();
        test_async_reset();
        test_alarm_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
